prog_loader: RTL and testbench

UART boot loader that receives a framed program image over a serial line and writes it word-by-word into the shared 16-bit instruction/data memory, starting at the core's reset PC (0x2400). It sits directly upstream of the core: it owns the memory write port while loading and holds the core stalled via `core_run` until a complete, valid image is in memory. Once loading succeeds, the loader releases the core and goes quiet until the next reset.

---
 rtl/prog_loader.sv | 242 ++++++++++++++++++++++++
 tb/tb_prog_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - UART boot loader that writes a framed image to memory and releases the core.
// Optional trailing XOR checksum is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
   parameter int          CLKS_PER_BIT = 434,
   parameter logic [14:0] LOAD_BASE    = 15'h2400,
   parameter int          MAX_WORDS    = 1024
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        rx_i,
   output logic [14:0] mem_addr_o,
   output logic [15:0] mem_wdata_o,
   output logic        mem_we_o,
   output logic        core_run_o,
   output logic        busy_o,
   output logic        err_o
);

   localparam int            CW      = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
   typedef enum logic [2:0] {F_IDLE, F_LEN_HI, F_LEN_LO, F_DATA_HI,
                             F_DATA_LO, F_CHECK, F_ERROR, F_DONE} f_state_e;

   // Synchronizer flops reset to the idle (high) line level so reset never fakes a start edge.
   logic rx_s1_q, rx_s2_q, rx_prev_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_s1_q   <= rx_i;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
      end
   end

   rx_state_e     rx_state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_idx_q;
   logic [7:0]    shift_q;
   logic          byte_valid_q;
   logic          frame_err_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rx_state_q   <= RX_IDLE;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         case (rx_state_q)
            RX_IDLE: begin
               if (rx_prev_q && !rx_s2_q) begin
                  cnt_q      <= '0;
                  rx_state_q <= RX_START;
               end
            end
            RX_START: begin
               if (cnt_q == HALF_M1) begin
                  cnt_q      <= '0;
                  bit_idx_q  <= '0;
                  rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q     <= '0;
                  shift_q   <= {rx_s2_q, shift_q[7:1]};
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
                     rx_state_q <= RX_STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt_q == FULL_M1) begin
                  byte_valid_q <= rx_s2_q;
                  frame_err_q  <= !rx_s2_q;
                  rx_state_q   <= RX_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   f_state_e    f_state_q;
   logic [7:0]  len_hi_q;
   logic [7:0]  data_hi_q;
   logic [15:0] len_q;
   logic [15:0] idx_q;
   logic [14:0] mem_addr_q;
   logic [15:0] mem_wdata_q;
   logic        mem_we_q;
   logic        core_run_q;
   logic        busy_q;
   logic        err_q;

   logic [15:0] len_d;
   logic [15:0] idx_d;
   logic [14:0] addr_d;

   assign len_d  = {len_hi_q, shift_q};
   assign idx_d  = idx_q + 16'd1;
   assign addr_d = LOAD_BASE + idx_q[14:0];

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0] xor_q;
   logic [7:0] xor_d;
   assign xor_d = xor_q ^ shift_q;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         f_state_q   <= F_IDLE;
         len_hi_q    <= '0;
         data_hi_q   <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         mem_addr_q  <= LOAD_BASE;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         core_run_q  <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         xor_q       <= '0;
`endif
      end else begin
         mem_we_q <= 1'b0;
         // Once DONE the line is ignored, so a bad stop bit cannot disturb a loaded core.
         if (frame_err_q && f_state_q != F_DONE) begin
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
            f_state_q <= F_IDLE;
         end else begin
            case (f_state_q)
               F_IDLE: begin
                  if (byte_valid_q && shift_q == 8'hA5) begin
                     busy_q    <= 1'b1;
                     f_state_q <= F_LEN_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
                     xor_q     <= '0;
`endif
                  end
               end
               F_LEN_HI: begin
                  if (byte_valid_q) begin
                     len_hi_q  <= shift_q;
                     f_state_q <= F_LEN_LO;
                  end
               end
               F_LEN_LO: begin
                  if (byte_valid_q) begin
                     len_q <= len_d;
                     idx_q <= '0;
                     if (len_d > 16'(MAX_WORDS)) begin
                        err_q     <= 1'b1;
                        busy_q    <= 1'b0;
                        f_state_q <= F_ERROR;
                     end else if (len_d == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        f_state_q <= F_CHECK;
`else
                        busy_q    <= 1'b0;
                        err_q     <= 1'b0;
                        f_state_q <= F_DONE;
`endif
                     end else begin
                        f_state_q <= F_DATA_HI;
                     end
                  end
               end
               F_DATA_HI: begin
                  if (byte_valid_q) begin
                     data_hi_q <= shift_q;
                     f_state_q <= F_DATA_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                     xor_q     <= xor_d;
`endif
                  end
               end
               F_DATA_LO: begin
                  if (byte_valid_q) begin
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= addr_d;
                     mem_wdata_q <= {data_hi_q, shift_q};
                     idx_q       <= idx_d;
`ifdef PROG_LOADER_CHECKSUM_EN
                     xor_q       <= xor_d;
                     f_state_q   <= (idx_d == len_q) ? F_CHECK : F_DATA_HI;
`else
                     if (idx_d == len_q) begin
                        busy_q    <= 1'b0;
                        err_q     <= 1'b0;
                        f_state_q <= F_DONE;
                     end else begin
                        f_state_q <= F_DATA_HI;
                     end
`endif
                  end
               end
`ifdef PROG_LOADER_CHECKSUM_EN
               F_CHECK: begin
                  if (byte_valid_q) begin
                     busy_q    <= 1'b0;
                     err_q     <= (shift_q != xor_q);
                     f_state_q <= (shift_q == xor_q) ? F_DONE : F_ERROR;
                  end
               end
`endif
               F_ERROR: f_state_q <= F_IDLE;
               F_DONE:  core_run_q <= 1'b1;
               default: f_state_q <= F_IDLE;
            endcase
         end
      end
   end

   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_we_o    = mem_we_q;
   assign core_run_o  = core_run_q;
   assign busy_o      = busy_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader; expected writes queued at stimulus time.
// Checksum expectations follow PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;

   localparam int CPB = 8;
`ifdef PROG_LOADER_CHECKSUM_EN
   localparam bit CS_EN = 1'b1;
`else
   localparam bit CS_EN = 1'b0;
`endif

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx    = 1'b1;
   logic [14:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic        core_run;
   logic        busy;
   logic        err;

   int          n_total = 0;
   int          n_bad   = 0;
   logic [30:0] sb_q[$];
   logic [7:0]  tx_q[$];
   logic        prev_we = 1'b0;
   logic [30:0] exp_wr;
   logic        exp_run2;
   logic        exp_err2;

   always #5 clk = ~clk;

   prog_loader #(
      .CLKS_PER_BIT (CPB),
      .LOAD_BASE    (15'h2400),
      .MAX_WORDS    (4)
   ) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .rx_i        (rx),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_we_o    (mem_we),
      .core_run_o  (core_run),
      .busy_o      (busy),
      .err_o       (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Write monitor: every strobe must match the head of the scoreboard and never repeat back-to-back.
   always @(negedge clk) begin
      if (mem_we) begin
         check("we_gap", {31'd0, prev_we}, 32'd0);
         check("wr_expected", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            exp_wr = sb_q.pop_front();
            check("wr", {1'b0, mem_addr, mem_wdata}, {1'b0, exp_wr});
         end
      end
      prev_we <= mem_we;
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(posedge clk);
      end
      rx = stop;
      repeat (CPB) @(posedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(posedge clk);
   endtask

   task automatic send_all();
      while (tx_q.size() != 0) send_byte(tx_q.pop_front(), 1'b1);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_addr"}, 32'(mem_addr), 32'h2400);
      check({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
      check({tag, "_we"}, 32'(mem_we), 32'h0);
      check({tag, "_run"}, 32'(core_run), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
      check({tag, "_err"}, 32'(err), 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic check_end(input string tag, input logic run, input logic e, input logic bsy);
      repeat (5) @(negedge clk);
      check({tag, "_sb"}, 32'(sb_q.size()), 32'd0);
      check({tag, "_run"}, 32'(core_run), 32'(run));
      check({tag, "_err"}, 32'(err), 32'(e));
      check({tag, "_busy"}, 32'(busy), 32'(bsy));
   endtask

   task automatic valid_one_word(input string tag);
      sb_q.push_back({15'h2400, 16'hBEEF});
      tx_q = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF};
      if (CS_EN) tx_q.push_back(8'h51);
      send_all();
      check_end(tag, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      check_reset("rst0");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Two-word frame with correct checksum.
      sb_q.push_back({15'h2400, 16'h1234});
      sb_q.push_back({15'h2401, 16'hABCD});
      tx_q = '{8'hA5, 8'h00, 8'h02};
      send_all();
      check("s1_busy_mid", 32'(busy), 32'd1);
      check("s1_run_mid", 32'(core_run), 32'd0);
      tx_q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
      if (CS_EN) tx_q.push_back(8'h40);
      send_all();
      check_end("s1", 1'b1, 1'b0, 1'b0);

      // Same frame with a wrong checksum byte; without checksum support the byte lands after DONE.
      do_reset();
      exp_run2 = !CS_EN;
      exp_err2 = CS_EN;
      sb_q.push_back({15'h2400, 16'h1234});
      sb_q.push_back({15'h2401, 16'hABCD});
      tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
      send_all();
      check_end("s2", exp_run2, exp_err2, 1'b0);

      // Empty image.
      do_reset();
      tx_q = '{8'hA5, 8'h00, 8'h00};
      if (CS_EN) tx_q.push_back(8'h00);
      send_all();
      check_end("s3", 1'b1, 1'b0, 1'b0);

      // Oversized length, then a good frame clears err.
      do_reset();
      tx_q = '{8'hA5, 8'h00, 8'h05};
      send_all();
      check_end("s4a", 1'b0, 1'b1, 1'b0);
      valid_one_word("s4b");

      // Noise, then a framing error on the data byte, then recovery.
      do_reset();
      tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01};
      send_all();
      send_byte(8'hBE, 1'b0);
      check_end("s5a", 1'b0, 1'b1, 1'b0);
      valid_one_word("s5b");

      // Reset pulse in the middle of the second data byte.
      do_reset();
      tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12};
      send_all();
      fork
         send_byte(8'h34, 1'b1);
         begin
            repeat (30) @(posedge clk);
            @(negedge clk) rst_n = 1'b0;
            @(negedge clk);
            check_reset("s6_rst");
            rst_n = 1'b1;
         end
      join
      repeat (200) @(posedge clk);
      check("s6_idle_sb", 32'(sb_q.size()), 32'd0);
      sb_q.push_back({15'h2400, 16'h1234});
      sb_q.push_back({15'h2401, 16'hABCD});
      tx_q = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      if (CS_EN) tx_q.push_back(8'h40);
      send_all();
      check_end("s6", 1'b1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
